writeback_unit: RTL and testbench

- Writer-side counterpart of register_file in the 8-bit pipelined RISC core: sits between EX (ALU output) and the register file write port.
- Registers ALU results in a single WB pipeline stage, drives reg_write/write_reg/write_data, keeps the architectural zero flag and a retired-instruction counter.
- Forwards in-flight results to operand reads so decode never sees a stale register value.

---
 rtl/core_pkg.sv | 25 ++
 rtl/fwd_mux.sv | 27 ++
 rtl/writeback_unit.sv | 90 +++++++++
 tb/tb_writeback_unit.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared constants and types for the 8-bit pipelined core.
// Covers datapath widths, the writeback entry record and the ALU op encodings.
package core_pkg;

  localparam int DATA_WIDTH     = 8;
  localparam int REG_ADDR_WIDTH = 3;
  localparam int CNT_WIDTH      = 16;
  localparam int NUM_REGS       = 1 << REG_ADDR_WIDTH;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_OR  = 2'b11
  } alu_op_t;

  typedef struct packed {
    logic                      valid;
    logic                      wen;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic [DATA_WIDTH-1:0]     data;
    logic                      zero;
  } wb_entry_t;

endpackage

// File: rtl/fwd_mux.sv
// Single-operand forward select.
// Priority: in-flight EX result, then the WB stage entry, then the register file.
module fwd_mux #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic [ADDR_WIDTH-1:0] rs,
  input  logic                  ex_fwd_en,
  input  logic [ADDR_WIDTH-1:0] ex_rd,
  input  logic [DATA_WIDTH-1:0] ex_result,
  input  logic                  wb_fwd_en,
  input  logic [ADDR_WIDTH-1:0] wb_rd,
  input  logic [DATA_WIDTH-1:0] wb_data,
  input  logic [DATA_WIDTH-1:0] rf_data,
  output logic [DATA_WIDTH-1:0] op
);

  always_comb begin
    // NOTE: default assignment first so every path drives op; no latch is inferred.
    op = rf_data;
    if (ex_fwd_en && ex_rd == rs)
      op = ex_result;
    else if (wb_fwd_en && wb_rd == rs)
      op = wb_data;
  end

endmodule

// File: rtl/writeback_unit.sv
// Single-stage writeback: registers EX results, drives the register file write port,
// keeps the zero flag and retired count, and forwards in-flight results to decode.
module writeback_unit #(
  parameter int DATA_WIDTH     = core_pkg::DATA_WIDTH,
  parameter int REG_ADDR_WIDTH = core_pkg::REG_ADDR_WIDTH,
  parameter int CNT_WIDTH      = core_pkg::CNT_WIDTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ex_valid,
  input  logic                      ex_wen,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
  input  logic [DATA_WIDTH-1:0]     ex_result,
  input  logic                      ex_zero,
  input  logic                      stall,
  input  logic                      flush,
  input  logic [REG_ADDR_WIDTH-1:0] rs1,
  input  logic [REG_ADDR_WIDTH-1:0] rs2,
  input  logic [DATA_WIDTH-1:0]     rf_data1,
  input  logic [DATA_WIDTH-1:0]     rf_data2,
  output logic                      reg_write,
  output logic [REG_ADDR_WIDTH-1:0] write_reg,
  output logic [DATA_WIDTH-1:0]     write_data,
  output logic [DATA_WIDTH-1:0]     op_a,
  output logic [DATA_WIDTH-1:0]     op_b,
  output logic                      zero_flag,
  output logic [CNT_WIDTH-1:0]      retired_count
);

  import core_pkg::*;

  wb_entry_t wb;
  logic      commit;
  logic      ex_fwd_en;
  logic      wb_fwd_en;

  assign commit     = wb.valid & ~stall & ~flush;
  assign reg_write  = commit & wb.wen;
  assign write_reg  = wb.rd;
  assign write_data = wb.data;

  // A flushed EX instruction must not forward; a held WB entry still does.
  assign ex_fwd_en = ex_valid & ex_wen & ~flush;
  assign wb_fwd_en = wb.valid & wb.wen;

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
    if (reset) begin
      wb            <= '0;
      zero_flag     <= 1'b0;
      retired_count <= '0;
    end else begin
      if (flush)
        wb.valid <= 1'b0;
      else if (!stall)
        wb <= '{valid: ex_valid, wen: ex_wen, rd: ex_rd, data: ex_result, zero: ex_zero};

      // Every committed instruction updates the flag, whether or not it writes a register.
      if (commit) begin
        zero_flag     <= wb.zero;
        retired_count <= retired_count + 1'b1;
      end
    end
  end

  fwd_mux #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_a (
    .rs        (rs1),
    .ex_fwd_en (ex_fwd_en),
    .ex_rd     (ex_rd),
    .ex_result (ex_result),
    .wb_fwd_en (wb_fwd_en),
    .wb_rd     (wb.rd),
    .wb_data   (wb.data),
    .rf_data   (rf_data1),
    .op        (op_a)
  );

  fwd_mux #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_b (
    .rs        (rs2),
    .ex_fwd_en (ex_fwd_en),
    .ex_rd     (ex_rd),
    .ex_result (ex_result),
    .wb_fwd_en (wb_fwd_en),
    .wb_rd     (wb.rd),
    .wb_data   (wb.data),
    .rf_data   (rf_data2),
    .op        (op_b)
  );

endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit: directed scenarios, random traffic and counter wrap,
// compared against an instruction-level model with an attached register file.
module tb_writeback_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       ex_valid, ex_wen, ex_zero, stall, flush;
  logic [2:0] ex_rd, rs1, rs2;
  logic [7:0] ex_result, rf_data1, rf_data2;
  logic       reg_write, zero_flag;
  logic [2:0] write_reg;
  logic [7:0] write_data, op_a, op_b;
  logic [15:0] retired_count;

  always #5 clk = ~clk;

  writeback_unit dut (
    .clk           (clk),
    .reset         (reset),
    .ex_valid      (ex_valid),
    .ex_wen        (ex_wen),
    .ex_rd         (ex_rd),
    .ex_result     (ex_result),
    .ex_zero       (ex_zero),
    .stall         (stall),
    .flush         (flush),
    .rs1           (rs1),
    .rs2           (rs2),
    .rf_data1      (rf_data1),
    .rf_data2      (rf_data2),
    .reg_write     (reg_write),
    .write_reg     (write_reg),
    .write_data    (write_data),
    .op_a          (op_a),
    .op_b          (op_b),
    .zero_flag     (zero_flag),
    .retired_count (retired_count)
  );

  // Register file attached to the DUT write port; it feeds the read data back.
  logic [7:0] tb_rf [8];
  assign rf_data1 = tb_rf[rs1];
  assign rf_data2 = tb_rf[rs2];
  always @(posedge clk) if (reg_write === 1'b1) tb_rf[write_reg] <= write_data;

  typedef struct {
    logic       rst, v, w;
    logic [2:0] rd;
    logic [7:0] res;
    logic       z, st, fl;
    logic [2:0] a, b;
  } stim_t;

  typedef struct {
    logic       wen;
    logic [2:0] rd;
    logic [7:0] data;
    logic       zero;
  } instr_t;

  // Reference model: the instruction waiting to retire, architectural registers, flag, count.
  instr_t     pending[$];
  logic [7:0] model_rf [8];
  logic       mzero;
  int         mcnt;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic stim_t mk(input logic v, w, input logic [2:0] rd, input logic [7:0] res,
                               input logic z, st, fl, input logic [2:0] a, b);
    stim_t s;
    s.rst = 1'b0; s.v = v; s.w = w; s.rd = rd; s.res = res;
    s.z = z; s.st = st; s.fl = fl; s.a = a; s.b = b;
    return s;
  endfunction

  function automatic logic [7:0] expected_operand(input stim_t s, input logic [2:0] src);
    if (s.v && s.w && !s.fl && s.rd == src) return s.res;
    if (pending.size() > 0 && pending[0].wen && pending[0].rd == src) return pending[0].data;
    return model_rf[src];
  endfunction

  // One clock: drive at negedge, check mid-cycle, then advance the model across the edge.
  task automatic step(input stim_t s);
    logic commit;
    @(negedge clk);
    reset = s.rst; ex_valid = s.v; ex_wen = s.w; ex_rd = s.rd; ex_result = s.res;
    ex_zero = s.z; stall = s.st; flush = s.fl; rs1 = s.a; rs2 = s.b;
    #2;
    commit = (pending.size() > 0) && !s.st && !s.fl;
    if (!s.rst) begin
      chk("reg_write", {31'd0, reg_write}, {31'd0, commit && pending[0].wen});
      if (commit && pending[0].wen) begin
        chk("write_reg", {29'd0, write_reg}, {29'd0, pending[0].rd});
        chk("write_data", {24'd0, write_data}, {24'd0, pending[0].data});
      end
      chk("op_a", {24'd0, op_a}, {24'd0, expected_operand(s, s.a)});
      chk("op_b", {24'd0, op_b}, {24'd0, expected_operand(s, s.b)});
      chk("zero_flag", {31'd0, zero_flag}, {31'd0, mzero});
      chk("retired_count", {16'd0, retired_count}, mcnt);
    end
    if (s.rst) begin
      pending.delete();
      mzero = 1'b0;
      mcnt  = 0;
    end else begin
      if (commit) begin
        if (pending[0].wen) model_rf[pending[0].rd] = pending[0].data;
        mzero = pending[0].zero;
        mcnt  = (mcnt + 1) % 65536;
      end
      if (s.fl) pending.delete();
      else if (!s.st) begin
        pending.delete();
        if (s.v) pending.push_back('{wen: s.w, rd: s.rd, data: s.res, zero: s.z});
      end
    end
  endtask

  initial begin
    stim_t rs;
    for (int i = 0; i < 8; i++) begin
      tb_rf[i]    = 8'h00;
      model_rf[i] = 8'h00;
    end
    mzero = 1'b0;
    mcnt  = 0;
    reset = 1'b1; ex_valid = 0; ex_wen = 0; ex_rd = 0; ex_result = 0; ex_zero = 0;
    stall = 0; flush = 0; rs1 = 0; rs2 = 0;

    // Reset held for two edges, then released.
    rs = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rs.rst = 1'b1;
    step(rs);
    step(rs);
    step(mk(0, 0, 0, 0, 0, 0, 0, 1, 1));
    chk("reset write_reg", {29'd0, write_reg}, 32'd0);
    chk("reset write_data", {24'd0, write_data}, 32'd0);

    // Single write of r2 = 15, readable from the register file two cycles later.
    step(mk(1, 1, 2, 8'd15, 0, 0, 0, 0, 0));
    step(mk(0, 0, 0, 0, 0, 0, 0, 2, 0));
    step(mk(0, 0, 0, 0, 0, 0, 0, 2, 2));

    // Back-to-back writes to r3: EX forward, EX over WB, then WB.
    step(mk(1, 1, 3, 8'hAA, 0, 0, 0, 3, 1));
    step(mk(1, 1, 3, 8'h55, 0, 0, 0, 3, 1));
    step(mk(0, 0, 0, 0, 0, 0, 0, 3, 3));
    step(mk(0, 0, 0, 0, 0, 0, 0, 3, 3));

    // Non-writing SUB with zero result sets the flag at commit.
    step(mk(1, 0, 1, 8'h00, 1, 0, 0, 1, 1));
    step(mk(0, 0, 0, 0, 0, 0, 0, 1, 1));
    step(mk(0, 0, 0, 0, 0, 0, 0, 1, 1));

    // r4 = 0xCC held by a three-cycle stall, then committed exactly once.
    step(mk(1, 1, 4, 8'hCC, 0, 0, 0, 0, 4));
    for (int i = 0; i < 3; i++) step(mk(1, 1, 7, 8'h77, 0, 1, 0, 0, 4));
    step(mk(0, 0, 0, 0, 0, 0, 0, 4, 4));
    step(mk(0, 0, 0, 0, 0, 0, 0, 4, 4));

    // Flush drops WB r5 and EX r6; neither register is written.
    step(mk(1, 1, 5, 8'h10, 0, 0, 0, 5, 6));
    step(mk(1, 1, 6, 8'h20, 0, 1, 1, 5, 6));
    step(mk(0, 0, 0, 0, 0, 0, 0, 5, 6));

    // Stall with nothing in WB has no effect.
    step(mk(0, 0, 0, 0, 0, 1, 0, 0, 7));

    // Random traffic including register 0, stalls and flushes.
    for (int i = 0; i < 400; i++) begin
      step(mk($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)),
              8'($urandom), $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
              $urandom_range(0, 7) == 0, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7))));
    end

    // Drive the counter up to 0xFFFF, then one more commit wraps it to zero.
    while (mcnt != 65535) step(mk(1, 0, 0, 8'h01, 0, 0, 0, 0, 0));
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    chk("retired_count wrap", {16'd0, retired_count}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
